gray_reader: RTL and testbench

Synchronous Gray-code input decoder: the receive-side counterpart to the LED Gray-code driver. Samples an asynchronous BITS-wide Gray-coded bus (absolute encoder, looped-back LED bank, or another board's Gray output), then synchronizes, debounces and converts it to binary. Classifies every accepted change as step up, step down or illegal jump, and maintains a signed position accumulator. Sits between board pins and fabric logic on the single system clock.

---
 rtl/gray_reader.sv | 124 ++++++++++++
 tb/tb_gray_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gray_reader.sv
// Gray-coded input decoder: synchronize, debounce, convert to binary, classify steps, track position.
// Optional saturating illegal-jump counter enabled by defining GRAY_READER_ERRCNT_EN.
module gray_reader #(
    parameter int BITS          = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int POS_W         = 16
) (
    input  logic             clki,
    input  logic             resetn,
    input  logic [BITS-1:0]  gray_in,
    output logic [BITS-1:0]  bin_out,
    output logic             valid,
    output logic             step_up,
    output logic             step_dn,
    output logic             err,
    output logic [POS_W-1:0] position,
    output logic [7:0]       err_cnt,
    output logic             state_dbg
);

    // Output protocol: valid rises with the first accepted value and holds until reset;
    // step_up/step_dn/err are single-cycle pulses registered with bin_out, no backpressure.

    typedef enum logic {INIT = 1'b0, TRACK = 1'b1} state_t;

    localparam logic [7:0]      STABLE = 8'(STABLE_CYCLES);
    localparam logic [BITS-1:0] ONE    = BITS'(1);
    localparam logic [BITS-1:0] MINUS1 = '1;

    state_t          state;
    logic [BITS-1:0] sync_q [SYNC_STAGES];
    logic [BITS-1:0] cand;
    logic [7:0]      cnt;
    logic [BITS-1:0] s;
    logic [BITS-1:0] dec;
    logic [BITS-1:0] delta;
    logic            changed;
    logic            accept;
    logic            err_evt;

    assign state_dbg = logic'(state);

    always_ff @(posedge clki) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Accept fires on the edge where the stability count first reaches STABLE_CYCLES.
    always_comb begin
        s       = sync_q[SYNC_STAGES-1];
        changed = (s != cand);
        accept  = changed ? (STABLE == 8'd1) : (cnt == STABLE - 8'd1);
        dec     = '0;
        for (int i = 0; i < BITS; i++) dec[i] = ^(s >> i);
        delta   = dec - bin_out;
        err_evt = accept && (state == TRACK) && (delta != '0) &&
                  (delta != ONE) && (delta != MINUS1);
    end

    always_ff @(posedge clki) begin
        if (!resetn) begin
            state    <= INIT;
            cand     <= '0;
            cnt      <= '0;
            bin_out  <= '0;
            valid    <= 1'b0;
            step_up  <= 1'b0;
            step_dn  <= 1'b0;
            err      <= 1'b0;
            position <= '0;
        end else begin
            step_up <= 1'b0;
            step_dn <= 1'b0;
            err     <= 1'b0;
            if (changed) begin
                cand <= s;
                cnt  <= 8'd1;
            end else if (cnt < STABLE) begin
                cnt <= cnt + 8'd1;
            end
            if (accept) begin
                bin_out <= dec;
                case (state)
                    INIT: begin
                        valid <= 1'b1;
                        state <= TRACK;
                    end
                    TRACK: begin
                        if (delta == ONE) begin
                            step_up  <= 1'b1;
                            position <= position + POS_W'(1);
                        end else if (delta == MINUS1) begin
                            step_dn  <= 1'b1;
                            position <= position - POS_W'(1);
                        end else if (delta != '0) begin
                            err <= 1'b1;
                        end
                    end
                    default: state <= INIT;
                endcase
            end
        end
    end

`ifdef GRAY_READER_ERRCNT_EN
    always_ff @(posedge clki) begin
        if (!resetn) begin
            err_cnt <= '0;
        end else if (err_evt && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = '0;
    logic unused_err_evt;
    assign unused_err_evt = err_evt;
`endif

endmodule

// File: tb/tb_gray_reader.sv
// Bench for gray_reader: directed and random Gray input, per-cycle scoreboard against a
// sample-history reference model.
module tb_gray_reader;

    localparam int BITS   = 5;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int POS_W  = 16;
    localparam int W      = BITS + 4 + POS_W + 8;

    typedef struct packed {
        logic [BITS-1:0]  bin;
        logic             valid;
        logic             up;
        logic             dn;
        logic             err;
        logic [POS_W-1:0] pos;
        logic [7:0]       ec;
    } obs_t;

    logic             clki = 1'b0;
    logic             resetn = 1'b0;
    logic [BITS-1:0]  gray_in = '0;
    logic [BITS-1:0]  bin_out;
    logic             valid;
    logic             step_up;
    logic             step_dn;
    logic             err;
    logic [POS_W-1:0] position;
    logic [7:0]       err_cnt;
    logic             state_dbg;

    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    gray_reader #(
        .BITS(BITS), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .POS_W(POS_W)
    ) dut (
        .clki(clki), .resetn(resetn), .gray_in(gray_in), .bin_out(bin_out),
        .valid(valid), .step_up(step_up), .step_dn(step_dn), .err(err),
        .position(position), .err_cnt(err_cnt), .state_dbg(state_dbg)
    );

    always #5 clki = ~clki;

    // Reference model: history of applied Gray values since reset; a value is accepted when
    // the delayed sample has been identical for exactly STABLE consecutive edges.
    logic [BITS-1:0] hist[$];
    int              k;
    int              run;
    logic [BITS-1:0] prev_s;
    obs_t            m;

    function automatic logic [BITS-1:0] g2b(input logic [BITS-1:0] g);
        logic [BITS-1:0] b;
        b = g;
        for (int i = 1; i < BITS; i++) b = b ^ (g >> i);
        return b;
    endfunction

    function automatic logic [BITS-1:0] b2g(input logic [BITS-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_edge(input logic [BITS-1:0] g, input logic r);
        logic [BITS-1:0] s;
        logic [BITS-1:0] v;
        logic [BITS-1:0] d;
        if (!r) begin
            hist.delete();
            k = 0;
            run = 0;
            prev_s = '0;
            m = '0;
            return;
        end
        k++;
        s = (k > SYNC) ? hist[k-1-SYNC] : '0;
        hist.push_back(g);
        run = (k == 1 || s != prev_s) ? 1 : run + 1;
        prev_s = s;
        m.up = 1'b0;
        m.dn = 1'b0;
        m.err = 1'b0;
        if (run == STABLE) begin
            v = g2b(s);
            if (!m.valid) begin
                m.valid = 1'b1;
            end else begin
                d = v - m.bin;
                if (d == BITS'(1)) begin
                    m.up = 1'b1;
                    m.pos = m.pos + 1'b1;
                end else if (d == {BITS{1'b1}}) begin
                    m.dn = 1'b1;
                    m.pos = m.pos - 1'b1;
                end else if (d != '0) begin
                    m.err = 1'b1;
`ifdef GRAY_READER_ERRCNT_EN
                    if (m.ec != 8'hFF) m.ec = m.ec + 8'd1;
`endif
                end
            end
            m.bin = v;
        end
    endtask

    task automatic cyc(input logic [BITS-1:0] g, input logic r);
        gray_in = g;
        resetn = r;
        @(posedge clki);
        #1;
        model_edge(g, r);
        exp_q.push_back(W'(m));
    endtask

    task automatic hold_g(input logic [BITS-1:0] g, input int n);
        repeat (n) cyc(g, 1'b1);
    endtask

    task automatic hold_b(input logic [BITS-1:0] b, input int n);
        hold_g(b2g(b), n);
    endtask

    always @(negedge clki) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            obs_t a;
            e = obs_t'(exp_q.pop_front());
            a = '{bin: bin_out, valid: valid, up: step_up, dn: step_dn, err: err,
                  pos: position, ec: err_cnt};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs @%0t: got bin=%0d valid=%b up=%b dn=%b err=%b pos=%h ec=%0d, need bin=%0d valid=%b up=%b dn=%b err=%b pos=%h ec=%0d",
                         $time, a.bin, a.valid, a.up, a.dn, a.err, a.pos, a.ec,
                         e.bin, e.valid, e.up, e.dn, e.err, e.pos, e.ec);
            end
        end
    end

    initial begin
        logic [BITS-1:0] cur;
        logic [BITS-1:0] other;
        int kind;
        model_edge('0, 1'b0);
        repeat (3) cyc('0, 1'b0);
        hold_g(5'b00110, 10);
        hold_g(5'b00111, 10);
        hold_g(5'b01111, 3);
        hold_g(5'b00111, 10);
        hold_g(5'b11110, 10);
        hold_g(5'b00000, 10);
        hold_g(5'b10000, 10);
        hold_g(5'b00000, 10);
        hold_g(5'b00001, 3);
        repeat (2) cyc(5'b00001, 1'b0);
        hold_g(5'b00001, 10);
        cur = 5'd1;
        for (int it = 0; it < 400; it++) begin
            kind = $urandom_range(0, 11);
            if (kind <= 3) begin
                cur = cur + 1'b1;
                hold_b(cur, $urandom_range(6, 10));
            end else if (kind <= 6) begin
                cur = cur - 1'b1;
                hold_b(cur, $urandom_range(6, 10));
            end else if (kind == 7) begin
                cur = BITS'($urandom_range(0, (1 << BITS) - 1));
                hold_b(cur, $urandom_range(6, 10));
            end else if (kind <= 9) begin
                other = BITS'($urandom_range(0, (1 << BITS) - 1));
                hold_b(other, $urandom_range(1, STABLE + 1));
                hold_b(cur, $urandom_range(6, 10));
            end else if (kind == 10) begin
                cur = cur + BITS'($urandom_range(0, 2)) - 1'b1;
                hold_b(cur, $urandom_range(1, 5));
            end else begin
                cur = BITS'($urandom_range(0, (1 << BITS) - 1));
                hold_b(cur, $urandom_range(0, 4));
                repeat ($urandom_range(1, 3)) cyc(b2g(cur), 1'b0);
                hold_b(cur, $urandom_range(6, 10));
            end
        end
        repeat (3) @(negedge clki);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
